// File: rtl/huc_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : huc_ram_arb_pkg
//  Brief    : Shared HuCard save-RAM types: arbiter states, slot record, defaults
//  Revision : 1.0  initial release
// ============================================================================
package huc_ram_arb_pkg;

    localparam int HUC_RAM_LAT = 2;
    localparam int HUC_RAM_AW  = 15;
    localparam int HUC_RAM_DW  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        CPU_HOLD = 2'd2,
        HOST_ACC = 2'd3
    } ArbState;

    typedef struct packed {
        logic [HUC_RAM_AW-1:0] addr;
        logic [HUC_RAM_DW-1:0] dati;
        logic                  we;
    } RamSlot;

endpackage
`default_nettype wire

// File: rtl/huc_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : huc_ram_arb
//  Brief    : CPU-priority arbiter/sequencer sharing the save-RAM with host DMA
//  Revision : 1.0  initial release
// ============================================================================
module huc_ram_arb
    import huc_ram_arb_pkg::*;
#(
    parameter int AW      = HUC_RAM_AW,
    parameter int DW      = HUC_RAM_DW,
    parameter int MEM_LAT = HUC_RAM_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_ce,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dati,
    output logic [DW-1:0] cpu_dato,
    input  logic          wp,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_dati,
    output logic          host_ack,
    output logic [DW-1:0] host_dato,
    output logic          dirty,
    input  logic          dirty_clr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dati,
    output logic          mem_oe,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dato
);

    localparam int          CW     = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] c_last = CW'(MEM_LAT);

    ArbState          r_state;
    ArbState          w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_ce_d;
    logic             r_cpu_pend;
    logic             r_dirty;
    logic             r_host_ack;
    logic [DW-1:0]    r_cpu_dato;
    logic [DW-1:0]    r_host_dato;
    RamSlot           r_cpu_slot;
    RamSlot           r_act;
    RamSlot           w_cpu_in;
    RamSlot           w_host_in;
    logic             w_cpu_go;
    logic             w_in_acc;
    logic             w_last;
    logic             w_cpu_commit;
    logic             w_enter_cpu;
    logic             w_enter_host;
    logic             w_unused;

    // Access type comes from cpu_we alone; cpu_oe carries no extra information.
    assign w_unused     = cpu_oe;

    assign w_cpu_go     = cpu_ce & ~r_ce_d;
    assign w_cpu_in     = '{addr: cpu_addr, dati: cpu_dati, we: cpu_we};
    assign w_host_in    = '{addr: host_addr, dati: host_dati, we: host_we};
    assign w_in_acc     = (r_state == CPU_ACC) || (r_state == HOST_ACC);
    assign w_last       = w_in_acc && (r_cnt == c_last);
    assign w_cpu_commit = (r_state == CPU_ACC) && w_last && r_act.we && !wp;
    assign w_enter_cpu  = (r_state != CPU_ACC) && (w_state_nxt == CPU_ACC);
    assign w_enter_host = (r_state == IDLE) && (w_state_nxt == HOST_ACC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cpu_go || r_cpu_pend)
                    w_state_nxt = CPU_ACC;
                else if (host_req)
                    w_state_nxt = HOST_ACC;
            end
            CPU_ACC: begin
                if (w_last)
                    w_state_nxt = cpu_ce ? CPU_HOLD : IDLE;
            end
            CPU_HOLD: begin
                if (!cpu_ce)
                    w_state_nxt = IDLE;
            end
            HOST_ACC: begin
                if (w_last)
                    w_state_nxt = (r_cpu_pend || w_cpu_go) ? CPU_ACC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from registered state so reset removes them without a clock.
    assign mem_oe    = w_in_acc && !r_act.we;
    assign mem_we    = w_last && r_act.we && ((r_state == HOST_ACC) || !wp);
    assign mem_addr  = r_act.addr;
    assign mem_dati  = r_act.dati;
    assign cpu_dato  = r_cpu_dato;
    assign host_dato = r_host_dato;
    assign host_ack  = r_host_ack;
    assign dirty     = r_dirty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ce_d      <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_dirty     <= 1'b0;
            r_host_ack  <= 1'b0;
            r_cpu_dato  <= {DW{1'b1}};
            r_host_dato <= '0;
            r_cpu_slot  <= '0;
            r_act       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ce_d     <= cpu_ce;
            r_cnt      <= (w_in_acc && !w_last) ? r_cnt + 1'b1 : '0;
            r_host_ack <= (r_state == HOST_ACC) && w_last;
            r_dirty    <= w_cpu_commit || (r_dirty && !dirty_clr);

            if (w_cpu_go)
                r_cpu_slot <= w_cpu_in;

            if (w_enter_cpu)
                r_cpu_pend <= 1'b0;
            else if (w_cpu_go && (r_state != IDLE))
                r_cpu_pend <= 1'b1;

            // A fresh start edge carries newer fields than the pending slot.
            if (w_enter_cpu)
                r_act <= w_cpu_go ? w_cpu_in : r_cpu_slot;
            else if (w_enter_host)
                r_act <= w_host_in;

            if (w_last && !r_act.we) begin
                if (r_state == CPU_ACC)
                    r_cpu_dato <= mem_dato;
                else
                    r_host_dato <= mem_dato;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huc_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huc_ram_arb
//  Brief    : Directed self-checking bench for huc_ram_arb with a 2-cycle RAM model
//  Revision : 1.0  initial release
// ============================================================================
module tb_huc_ram_arb;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_ce, cpu_oe, cpu_we, wp;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dati, cpu_dato;
    logic          host_req, host_we, host_ack;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_dati, host_dato;
    logic          dirty, dirty_clr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dati, mem_dato;
    logic          mem_oe, mem_we;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] r_d1;

    int n_total = 0;
    int n_bad   = 0;

    logic          oe_log    [1:6];
    logic          we_log    [1:6];
    logic          dirty_log [1:6];
    logic [DW-1:0] dato_log  [1:6];
    logic [AW-1:0] addr_log  [1:6];

    huc_ram_arb #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce    (cpu_ce),
        .cpu_oe    (cpu_oe),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_dati  (cpu_dati),
        .cpu_dato  (cpu_dato),
        .wp        (wp),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_dati (host_dati),
        .host_ack  (host_ack),
        .host_dato (host_dato),
        .dirty     (dirty),
        .dirty_clr (dirty_clr),
        .mem_addr  (mem_addr),
        .mem_dati  (mem_dati),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_dato  (mem_dato)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears two cycles after the address.
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_dati;
        r_d1     <= ram[mem_addr];
        mem_dato <= r_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle in which cpu_ce rises; logs cover cycles 1..6.
    task automatic run_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int clr_at);
        cpu_ce   = 1'b1;
        cpu_we   = we;
        cpu_oe   = ~we;
        cpu_addr = a;
        cpu_dati = d;
        for (int c = 1; c <= 6; c++) begin
            tick();
            oe_log[c]    = mem_oe;
            we_log[c]    = mem_we;
            dirty_log[c] = dirty;
            dato_log[c]  = cpu_dato;
            addr_log[c]  = mem_addr;
            dirty_clr    = (c == clr_at);
        end
        cpu_ce    = 1'b0;
        cpu_we    = 1'b0;
        cpu_oe    = 1'b0;
        dirty_clr = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic          any_we;
        logic          ack_seen;
        int            ack_cyc;
        int            n_ack;
        int            last_ack;

        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[15'h1234] = 8'hA5;
        ram[15'h7FFF] = 8'h5A;

        rst = 1'b1;
        cpu_ce = 0; cpu_oe = 0; cpu_we = 0; wp = 0;
        cpu_addr = '0; cpu_dati = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_dati = '0;
        dirty_clr = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_mem_oe",    32'(mem_oe),    32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_cpu_dato",  32'(cpu_dato),  32'hFF);
        check("rst_host_dato", 32'(host_dato), 32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_dirty",     32'(dirty),     32'd0);
        check("rst_host_ack",  32'(host_ack),  32'd0);

        // CPU read from an idle block
        run_cpu(1'b0, 15'h1234, 8'h00, 0);
        for (int c = 1; c <= 4; c++)
            check($sformatf("rd_oe_c%0d", c), 32'(oe_log[c]), (c <= 3) ? 32'd1 : 32'd0);
        check("rd_addr",    32'(addr_log[1]), 32'h1234);
        check("rd_dato_c3", 32'(dato_log[3]), 32'hFF);
        check("rd_dato_c4", 32'(dato_log[4]), 32'hA5);
        any_we = 1'b0;
        for (int c = 1; c <= 6; c++) any_we |= we_log[c];
        check("rd_no_we", 32'(any_we), 32'd0);

        // Unprotected CPU write
        run_cpu(1'b1, 15'h0010, 8'h3C, 0);
        for (int c = 1; c <= 5; c++)
            check($sformatf("wr_we_c%0d", c), 32'(we_log[c]), (c == 3) ? 32'd1 : 32'd0);
        check("wr_ram",   32'(ram[15'h0010]), 32'h3C);
        check("wr_dirty", 32'(dirty_log[4]),  32'd1);

        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        check("clr_alone", 32'(dirty), 32'd0);

        // Write-protected CPU write
        wp = 1'b1;
        run_cpu(1'b1, 15'h0010, 8'h55, 0);
        wp = 1'b0;
        any_we = 1'b0;
        for (int c = 1; c <= 6; c++) any_we |= we_log[c];
        check("wp_no_we", 32'(any_we),        32'd0);
        check("wp_dirty", 32'(dirty),         32'd0);
        check("wp_ram",   32'(ram[15'h0010]), 32'h3C);

        // dirty_clr colliding with the commit cycle
        run_cpu(1'b1, 15'h0020, 8'h77, 3);
        check("clr_vs_set_we",    32'(we_log[3]),     32'd1);
        check("clr_vs_set_dirty", 32'(dirty_log[4]),  32'd1);
        check("clr_vs_set_after", 32'(dirty),         32'd1);
        check("clr_vs_set_ram",   32'(ram[15'h0020]), 32'h77);

        // Host read with a colliding CPU read at cycle 2
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h7FFF;
        ack_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (host_ack && ack_cyc < 0) ack_cyc = c;
            if (c == 1) check("col_host_addr", 32'(mem_addr), 32'h7FFF);
            if (c == 2) begin
                cpu_ce = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
            end
            if (c == 4) begin
                check("col_host_dato", 32'(host_dato), 32'h5A);
                check("col_cpu_oe",    32'(mem_oe),    32'd1);
                check("col_cpu_addr",  32'(mem_addr),  32'h0010);
                host_req = 1'b0;
            end
            if (c == 6) check("col_dato_c6", 32'(cpu_dato), 32'hA5);
            if (c == 7) check("col_dato_c7", 32'(cpu_dato), 32'h3C);
        end
        check("col_ack_cyc", 32'(ack_cyc), 32'd4);
        cpu_ce = 1'b0; cpu_oe = 1'b0;
        repeat (2) tick();

        // Host holds req across four writes
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0200; host_dati = 8'hC0;
        n_ack = 0;
        last_ack = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (host_ack) begin
                if (n_ack > 0)
                    check($sformatf("hw_gap%0d_ge4", n_ack), 32'(c - last_ack >= 4), 32'd1);
                n_ack++;
                last_ack = c;
                if (n_ack == 4) begin
                    host_req = 1'b0;
                end else begin
                    host_addr = 15'h0200 + 15'(n_ack);
                    host_dati = 8'hC0 + 8'(n_ack);
                end
            end
        end
        check("hw_n_ack", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("hw_ram%0d", i), 32'(ram[15'h0200 + 15'(i)]), 32'hC0 + 32'(i));

        // Reset asserted during the host write strobe
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0100; host_dati = 8'h99;
        for (int c = 1; c <= 3; c++) tick();
        check("rstw_we_pre", 32'(mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstw_we_async", 32'(mem_we), 32'd0);
        check("rstw_oe_async", 32'(mem_oe), 32'd0);
        host_req = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin tick(); ack_seen |= host_ack; end
        rst = 1'b0;
        repeat (3) begin tick(); ack_seen |= host_ack; end
        check("rstw_no_ack",    32'(ack_seen),      32'd0);
        check("rstw_ram",       32'(ram[15'h0100]), 32'h00);
        check("rstw_mem_addr",  32'(mem_addr),      32'h0);
        check("rstw_mem_dati",  32'(mem_dati),      32'h0);
        check("rstw_cpu_dato",  32'(cpu_dato),      32'hFF);
        check("rstw_host_dato", 32'(host_dato),     32'h0);
        check("rstw_dirty",     32'(dirty),         32'd0);

        // Block must be back in IDLE: a CPU read starts immediately
        run_cpu(1'b0, 15'h1234, 8'h00, 0);
        check("post_rst_oe_c1",   32'(oe_log[1]),   32'd1);
        check("post_rst_dato_c4", 32'(dato_log[4]), 32'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
